// File: rtl/id_ex_if.sv
// Bundle of ID-side decode fields, MEM/WB forwarding sources and EX-side
// outputs exchanged between the pipeline and the ID/EX stage.
interface id_ex_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic [1:0]      id_use_rs;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [3:0]      id_fs;
    logic [1:0]      id_src;
    logic [4:0]      id_ctrl;
    logic            flush;
    logic [RA_W-1:0] mem_rd;
    logic            mem_reg_write;
    logic [XLEN-1:0] mem_result;
    logic [RA_W-1:0] wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_data;
    logic            stall_id;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [RA_W-1:0] ex_rd;
    logic [3:0]      ex_fs;
    logic [4:0]      ex_ctrl;
    logic [XLEN-1:0] fu_a;
    logic [XLEN-1:0] fu_b;
    logic [XLEN-1:0] ex_store_data;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs,
               id_rs1_data, id_rs2_data, id_imm, id_fs, id_src, id_ctrl,
               flush, mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_data,
        input  stall_id, ex_valid, ex_pc, ex_rd, ex_fs, ex_ctrl,
               fu_a, fu_b, ex_store_data
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs,
               id_rs1_data, id_rs2_data, id_imm, id_fs, id_src, id_ctrl,
               flush, mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_data,
        output stall_id, ex_valid, ex_pc, ex_rd, ex_fs, ex_ctrl,
               fu_a, fu_b, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ID-side WB bypass, load-use stall detection
// and EX-side MEM/WB operand forwarding feeding the FU.
module id_ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic   clk,
    input  logic   rst,
    id_ex_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [3:0]      fs;
        logic [1:0]      src;
        logic [4:0]      ctrl;
    } ex_reg_t;

    ex_reg_t         ex_q;
    ex_reg_t         ex_d;
    logic            hz_c;
    logic [XLEN-1:0] id_rs1_byp_c;
    logic [XLEN-1:0] id_rs2_byp_c;
    logic [XLEN-1:0] fwd1_c;
    logic [XLEN-1:0] fwd2_c;

    // WB value written this cycle replaces stale register-file reads
    always_comb begin
        id_rs1_byp_c = bus.id_rs1_data;
        id_rs2_byp_c = bus.id_rs2_data;
        if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs1))
            id_rs1_byp_c = bus.wb_data;
        if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs2))
            id_rs2_byp_c = bus.wb_data;
    end

    // Load in EX whose result a valid ID instruction needs
    always_comb begin
        hz_c = ex_q.valid && ex_q.ctrl[3] && (ex_q.rd != '0) && bus.id_valid &&
               ((bus.id_use_rs[0] && (ex_q.rd == bus.id_rs1)) ||
                (bus.id_use_rs[1] && (ex_q.rd == bus.id_rs2)));
    end

    always_comb begin
        ex_d.valid    = bus.id_valid;
        ex_d.pc       = bus.id_pc;
        ex_d.rs1      = bus.id_rs1;
        ex_d.rs2      = bus.id_rs2;
        ex_d.rd       = bus.id_rd;
        ex_d.rs1_data = id_rs1_byp_c;
        ex_d.rs2_data = id_rs2_byp_c;
        ex_d.imm      = bus.id_imm;
        ex_d.fs       = bus.id_fs;
        ex_d.src      = bus.id_src;
        ex_d.ctrl     = bus.id_ctrl;
        if (bus.flush || hz_c) begin
            ex_d.valid = 1'b0;
            ex_d.ctrl  = '0;
            ex_d.fs    = '0;
            ex_d.rd    = '0;
        end else if (!bus.id_valid) begin
            ex_d.ctrl = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    // MEM result is younger than WB data, so it wins; x0 is never forwarded
    always_comb begin
        fwd1_c = ex_q.rs1_data;
        if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == ex_q.rs1))
            fwd1_c = bus.mem_result;
        else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == ex_q.rs1))
            fwd1_c = bus.wb_data;

        fwd2_c = ex_q.rs2_data;
        if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == ex_q.rs2))
            fwd2_c = bus.mem_result;
        else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == ex_q.rs2))
            fwd2_c = bus.wb_data;
    end

    assign bus.stall_id      = hz_c && !bus.flush;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_fs         = ex_q.fs;
    assign bus.ex_ctrl       = ex_q.ctrl;
    assign bus.fu_a          = ex_q.src[0] ? ex_q.pc  : fwd1_c;
    assign bus.fu_b          = ex_q.src[1] ? ex_q.imm : fwd2_c;
    assign bus.ex_store_data = fwd2_c;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, x0, load-use
// stall, flush override, ID-side bypass and operand source muxing.
module tb_id_ex_stage;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    id_ex_if #(.XLEN(32), .RA_W(5)) bus ();

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fwd_off();
        bus.mem_rd        = '0;
        bus.mem_reg_write = 1'b0;
        bus.mem_result    = '0;
        bus.wb_rd         = '0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_data       = '0;
    endtask

    task automatic id_issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [1:0] use_rs,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                            input logic [3:0] fs, input logic [1:0] src, input logic [4:0] ctrl);
        bus.id_valid    = 1'b1;
        bus.id_pc       = pc;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_use_rs   = use_rs;
        bus.id_rs1_data = d1;
        bus.id_rs2_data = d2;
        bus.id_imm      = imm;
        bus.id_fs       = fs;
        bus.id_src      = src;
        bus.id_ctrl     = ctrl;
    endtask

    task automatic id_idle();
        id_issue('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        bus.id_valid = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.flush = 1'b0;
        fwd_off();
        id_idle();

        // Reset state
        #3;
        check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_ex_ctrl",  32'(bus.ex_ctrl),  32'd0);
        check("rst_stall",    32'(bus.stall_id), 32'd0);
        check("rst_fu_a",     bus.fu_a,          32'd0);
        tick();
        rst = 1'b0;

        // add x3,x1,x2 with x1=5, x2=7
        id_issue(32'h100, 5'd1, 5'd2, 5'd3, 2'b11, 32'd5, 32'd7, 32'd0, 4'b0000, 2'b00, 5'b10000);
        tick();
        check("add_valid", 32'(bus.ex_valid), 32'd1);
        check("add_fs",    32'(bus.ex_fs),    32'd0);
        check("add_rd",    32'(bus.ex_rd),    32'd3);
        check("add_ctrl",  32'(bus.ex_ctrl),  32'h10);
        check("add_fu_a",  bus.fu_a,          32'd5);
        check("add_fu_b",  bus.fu_b,          32'd7);
        check("add_st",    bus.ex_store_data, 32'd7);
        id_idle();

        // MEM beats WB on x1
        bus.mem_rd = 5'd1; bus.mem_reg_write = 1'b1; bus.mem_result = 32'h10;
        bus.wb_rd  = 5'd1; bus.wb_reg_write  = 1'b1; bus.wb_data    = 32'h20;
        #1;
        check("fwd_mem_wins", bus.fu_a, 32'h10);
        check("fwd_b_none",   bus.fu_b, 32'd7);
        bus.mem_rd = 5'd2;
        #1;
        check("fwd_wb_a",  bus.fu_a,          32'h20);
        check("fwd_mem_b", bus.fu_b,          32'h10);
        check("fwd_mem_st", bus.ex_store_data, 32'h10);
        fwd_off();
        #1;
        check("fwd_off_a", bus.fu_a, 32'd5);

        // x0 is never forwarded
        id_issue(32'h104, 5'd0, 5'd0, 5'd8, 2'b11, 32'd0, 32'd0, 32'd0, 4'b0100, 2'b00, 5'b10000);
        tick();
        id_idle();
        bus.mem_rd = 5'd0; bus.mem_reg_write = 1'b1; bus.mem_result = 32'hDEAD;
        bus.wb_rd  = 5'd0; bus.wb_reg_write  = 1'b1; bus.wb_data    = 32'hBEEF;
        #1;
        check("x0_fu_a", bus.fu_a, 32'd0);
        check("x0_fu_b", bus.fu_b, 32'd0);
        check("x0_fs",   32'(bus.ex_fs), 32'h4);
        fwd_off();

        // lw x5 then add x6,x5,x1: one stall cycle, bubble, then WB forward
        id_issue(32'h108, 5'd1, 5'd0, 5'd5, 2'b01, 32'h100, 32'd0, 32'd4, 4'b0000, 2'b10, 5'b11001);
        tick();
        check("lw_ctrl", 32'(bus.ex_ctrl), 32'h19);
        id_issue(32'h10C, 5'd5, 5'd1, 5'd6, 2'b11, 32'd0, 32'd5, 32'd0, 4'b0000, 2'b00, 5'b10000);
        #1;
        check("lu_stall", 32'(bus.stall_id), 32'd1);
        tick();
        check("lu_bub_valid", 32'(bus.ex_valid), 32'd0);
        check("lu_bub_ctrl",  32'(bus.ex_ctrl),  32'd0);
        check("lu_bub_rd",    32'(bus.ex_rd),    32'd0);
        check("lu_stall_end", 32'(bus.stall_id), 32'd0);
        tick();
        check("lu_add_valid", 32'(bus.ex_valid), 32'd1);
        check("lu_add_rd",    32'(bus.ex_rd),    32'd6);
        id_idle();
        bus.wb_rd = 5'd5; bus.wb_reg_write = 1'b1; bus.wb_data = 32'h99;
        #1;
        check("lu_fu_a", bus.fu_a, 32'h99);
        check("lu_fu_b", bus.fu_b, 32'd5);
        fwd_off();

        // Flush overrides the load-use stall
        id_issue(32'h110, 5'd1, 5'd0, 5'd5, 2'b01, 32'h100, 32'd0, 32'd4, 4'b0000, 2'b10, 5'b11001);
        tick();
        id_issue(32'h114, 5'd5, 5'd1, 5'd6, 2'b11, 32'd0, 32'd5, 32'd0, 4'b0000, 2'b00, 5'b10000);
        bus.flush = 1'b1;
        #1;
        check("fl_stall", 32'(bus.stall_id), 32'd0);
        tick();
        bus.flush = 1'b0;
        check("fl_valid", 32'(bus.ex_valid), 32'd0);
        check("fl_ctrl",  32'(bus.ex_ctrl),  32'd0);
        check("fl_rd",    32'(bus.ex_rd),    32'd0);
        id_idle();

        // ID-side bypass: WB x4=0xAB while ID reads stale 0
        id_issue(32'h118, 5'd4, 5'd2, 5'd7, 2'b11, 32'd0, 32'h33, 32'd0, 4'b0111, 2'b00, 5'b10000);
        bus.wb_rd = 5'd4; bus.wb_reg_write = 1'b1; bus.wb_data = 32'hAB;
        tick();
        fwd_off();
        id_idle();
        #1;
        check("byp_fu_a", bus.fu_a, 32'hAB);
        check("byp_fu_b", bus.fu_b, 32'h33);

        // src_a_pc selects PC
        id_issue(32'h1000, 5'd1, 5'd2, 5'd9, 2'b11, 32'h55, 32'h33, 32'h7F0, 4'b0000, 2'b01, 5'b10000);
        tick();
        check("srca_fu_a", bus.fu_a, 32'h1000);
        check("srca_fu_b", bus.fu_b, 32'h33);
        check("srca_pc",   bus.ex_pc, 32'h1000);

        // src_b_imm selects imm; store data still forwarded rs2
        id_issue(32'h1004, 5'd1, 5'd2, 5'd0, 2'b11, 32'h55, 32'h33, 32'h7F0, 4'b0000, 2'b10, 5'b00100);
        tick();
        id_idle();
        check("srcb_fu_a", bus.fu_a,          32'h55);
        check("srcb_fu_b", bus.fu_b,          32'h7F0);
        check("srcb_st",   bus.ex_store_data, 32'h33);
        bus.mem_rd = 5'd2; bus.mem_reg_write = 1'b1; bus.mem_result = 32'h44;
        #1;
        check("srcb_fu_b_fwd", bus.fu_b,          32'h7F0);
        check("srcb_st_fwd",   bus.ex_store_data, 32'h44);
        fwd_off();

        // Invalid ID instruction: ctrl forced to zero, fs still latched
        id_issue(32'h2000, 5'd1, 5'd2, 5'd3, 2'b11, 32'd1, 32'd2, 32'd0, 4'b1000, 2'b00, 5'b11111);
        bus.id_valid = 1'b0;
        tick();
        check("inv_valid", 32'(bus.ex_valid), 32'd0);
        check("inv_ctrl",  32'(bus.ex_ctrl),  32'd0);
        check("inv_fs",    32'(bus.ex_fs),    32'h8);

        // Mid-stream async reset clears EX without a clock edge
        id_issue(32'h3000, 5'd1, 5'd2, 5'd3, 2'b11, 32'd1, 32'd2, 32'd0, 4'b1101, 2'b00, 5'b10000);
        tick();
        check("mid_valid_pre", 32'(bus.ex_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_valid", 32'(bus.ex_valid), 32'd0);
        check("mid_pc",    bus.ex_pc,         32'd0);
        check("mid_fs",    32'(bus.ex_fs),    32'd0);
        check("mid_ctrl",  32'(bus.ex_ctrl),  32'd0);
        tick();
        rst = 1'b0;
        id_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name:
id_ex_stage

Overview:
ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection. It sits directly upstream of the EX functional unit and drives that unit's FS, A and B inputs. It captures decoded fields from ID each cycle and resolves RAW hazards against the MEM and WB stages.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register index width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_pc  input  XLEN  PC of ID instruction
id_rs1  input  RA_W  source register 1 index
id_rs2  input  RA_W  source register 2 index
id_rd  input  RA_W  destination index
id_use_rs  input  2  {uses_rs2, uses_rs1}
id_rs1_data  input  XLEN  register file read port 1
id_rs2_data  input  XLEN  register file read port 2
id_imm  input  XLEN  decoded immediate
id_fs  input  4  FU function select (0000 add, 1000 sub, 0010 slt, 0011 sltu, 0100 xor, 0110 or, 0111 and, 0001 sll, 0101 srl, 1101 sra)
id_src  input  2  {src_b_imm, src_a_pc}
id_ctrl  input  5  {reg_write, mem_read, mem_write, wb_sel[1:0]}
flush  input  1  branch/jump redirect; kill ID instruction
mem_rd  input  RA_W  EX/MEM destination
mem_reg_write  input  1  EX/MEM writes rd
mem_result  input  XLEN  EX/MEM ALU result
wb_rd  input  RA_W  MEM/WB destination
wb_reg_write  input  1  MEM/WB writes rd
wb_data  input  XLEN  MEM/WB writeback value
stall_id  output  1  freeze PC and IF/ID (load-use)
ex_valid  output  1  EX holds a real instruction
ex_pc  output  XLEN  registered PC
ex_rd  output  RA_W  registered rd
ex_fs  output  4  to FU FS
ex_ctrl  output  5  registered control bundle
fu_a  output  XLEN  to FU A
fu_b  output  XLEN  to FU B
ex_store_data  output  XLEN  forwarded rs2 for stores

Behaviour:
- Reset (async): all registered state 0; ex_valid=0, ex_pc=0, ex_rd=0, ex_fs=0, ex_ctrl=0. fu_a, fu_b and ex_store_data then evaluate to 0 unless forwarding is active. stall_id=0.
- Latency: one cycle from ID to EX. Registered fields: valid, pc, rs1, rs2, rd, rs1/rs2 data, imm, fs, src, ctrl.
- ID-side bypass: if wb_reg_write and wb_rd!=0 and wb_rd==id_rsN, the latched rsN data is wb_data instead of id_rsN_data. The register file therefore needs no internal write-through.
- Load-use hazard: hz = ex_valid & ex_ctrl[3] & ex_rd!=0 & id_valid & ((use_rs1 & ex_rd==id_rs1) | (use_rs2 & ex_rd==id_rs2)). stall_id = hz & ~flush.
- Register update priority: flush first, then hz, then normal.
  - flush or hz: load a bubble (valid=0, ctrl=0, fs=0, rd=0; other fields don't-care).
  - Normal: load the ID fields; valid=id_valid. If id_valid=0, ctrl is forced to 0.
- EX forwarding (combinational, per source N):
  - fwdN = mem_result when mem_reg_write & mem_rd!=0 & mem_rd==ex_rsN.
  - Else wb_data when wb_reg_write & wb_rd!=0 & wb_rd==ex_rsN.
  - Else the latched data. MEM has priority over WB. x0 is never forwarded.
- fu_a = src_a_pc ? ex_pc : fwd1. fu_b = src_b_imm ? ex_imm : fwd2. ex_store_data = fwd2 always.
- Forwarding ignores ex_valid; downstream qualifies on ex_valid/ex_ctrl.
- Reset asserted mid-stream clears EX to a bubble immediately, without waiting for a clock edge.

Test Plan:
- Reset → ex_valid=0, ex_ctrl=0 immediately. Release, then issue add x3,x1,x2 with x1=5, x2=7 → next cycle ex_fs=0000, fu_a=5, fu_b=7, ex_rd=3.
- EX/MEM writes x1=0x10 and MEM/WB writes x1=0x20 while EX reads x1 → fu_a=0x10 (MEM wins). With MEM writing x2 instead → fu_a=0x20.
- Forward to x0: mem_rd=0, mem_reg_write=1, ex_rs1=0, latched data 0 → fu_a=0.
- lw x5 in EX, ID add x6,x5,x1 → stall_id=1 for exactly one cycle, bubble enters EX (ex_valid=0, ex_ctrl=0). Next cycle the add enters; once the load reaches WB (WB data 0x99), fu_a=0x99.
- Load-use condition with flush=1 in the same cycle → stall_id=0, bubble loaded.
- WB writes x4=0xAB while ID reads x4 with stale register file data 0 → following cycle fu_a=0xAB (ID-side bypass). With id_src=01, fu_a=ex_pc; with id_src=10, fu_b=ex_imm and ex_store_data still equals forwarded rs2.
